// File: rtl/i2s_dac_tx.sv
// I2S audio DAC serializer: one-entry stereo sample buffer feeding a master-mode bit/LR clock
// generator. Define LEFT_JUSTIFIED_EN for left-justified framing (no delay bit, LRCK high = left).
module i2s_dac_tx #(
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned HALF_FRAME_CLKS = 250,
    parameter int unsigned BCLK_DIV        = 10
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] s_left,
    input  logic [DATA_WIDTH-1:0] s_right,
    input  logic                  s_valid,
    output logic                  s_ready,
    output logic                  sample_tick,
    output logic                  underrun,
    output logic                  AUD_BCLK,
    output logic                  AUD_DACLRCK,
    output logic                  AUD_DACDAT
);

    localparam int unsigned Slots = HALF_FRAME_CLKS / BCLK_DIV;
    localparam int unsigned PW    = $clog2(BCLK_DIV);
    localparam int unsigned BW    = $clog2(Slots);

`ifdef LEFT_JUSTIFIED_EN
    localparam logic LrckRst = 1'b1;
`else
    localparam logic LrckRst = 1'b0;
`endif

    logic [PW-1:0]         p_q, p_d;
    logic [BW-1:0]         b_q, b_d;
    logic                  side_q, side_d;
    logic                  hold_full_q, hold_full_d;
    logic [DATA_WIDTH-1:0] hold_l_q, hold_l_d, hold_r_q, hold_r_d;
    logic [DATA_WIDTH-1:0] sh_l_q, sh_l_d, sh_r_q, sh_r_d;
    logic                  bclk_q, bclk_d, lrck_q, lrck_d, dat_q, dat_d;
    logic                  tick_q, tick_d, urun_q, urun_d;

    logic                  p_wrap, b_wrap, frame_start, load;
    logic [DATA_WIDTH-1:0] word, shifted;

    always_comb begin
        p_wrap      = (p_q == PW'(BCLK_DIV - 1));
        b_wrap      = (b_q == BW'(Slots - 1));
        frame_start = (p_q == '0) && (b_q == '0) && !side_q;

        p_d    = p_wrap ? '0 : p_q + PW'(1);
        b_d    = b_q;
        if (p_wrap) begin
            b_d = b_wrap ? '0 : b_q + BW'(1);
        end
        side_d = side_q ^ (p_wrap & b_wrap);
    end

    // A full buffer at frame start always wins: s_ready is low then, so no transfer can collide.
    always_comb begin
        load        = frame_start && hold_full_q;
        hold_full_d = hold_full_q;
        hold_l_d    = hold_l_q;
        hold_r_d    = hold_r_q;
        sh_l_d      = sh_l_q;
        sh_r_d      = sh_r_q;
        if (load) begin
            sh_l_d      = hold_l_q;
            sh_r_d      = hold_r_q;
            hold_full_d = 1'b0;
        end else if (s_valid && !hold_full_q) begin
            hold_l_d    = s_left;
            hold_r_d    = s_right;
            hold_full_d = 1'b1;
        end
    end

    always_comb begin
        // Left-justified needs the new word's MSB in the very cycle it is loaded.
        word   = side_q ? sh_r_q : (load ? hold_l_q : sh_l_q);
        bclk_d = (p_q >= PW'(BCLK_DIV / 2));
        tick_d = frame_start;
        urun_d = frame_start && !hold_full_q;
`ifdef LEFT_JUSTIFIED_EN
        lrck_d  = ~side_q;
        shifted = word << b_q;
        dat_d   = (b_q < BW'(DATA_WIDTH)) && shifted[DATA_WIDTH-1];
`else
        lrck_d  = side_q;
        shifted = word << (b_q - BW'(1));
        dat_d   = (b_q != '0) && (b_q <= BW'(DATA_WIDTH)) && shifted[DATA_WIDTH-1];
`endif
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            p_q         <= '0;
            b_q         <= '0;
            side_q      <= 1'b0;
            hold_full_q <= 1'b0;
            hold_l_q    <= '0;
            hold_r_q    <= '0;
            sh_l_q      <= '0;
            sh_r_q      <= '0;
            bclk_q      <= 1'b0;
            lrck_q      <= LrckRst;
            dat_q       <= 1'b0;
            tick_q      <= 1'b0;
            urun_q      <= 1'b0;
        end else begin
            p_q         <= p_d;
            b_q         <= b_d;
            side_q      <= side_d;
            hold_full_q <= hold_full_d;
            hold_l_q    <= hold_l_d;
            hold_r_q    <= hold_r_d;
            sh_l_q      <= sh_l_d;
            sh_r_q      <= sh_r_d;
            bclk_q      <= bclk_d;
            lrck_q      <= lrck_d;
            dat_q       <= dat_d;
            tick_q      <= tick_d;
            urun_q      <= urun_d;
        end
    end

    assign s_ready     = !hold_full_q;
    assign sample_tick = tick_q;
    assign underrun    = urun_q;
    assign AUD_BCLK    = bclk_q;
    assign AUD_DACLRCK = lrck_q;
    assign AUD_DACDAT  = dat_q;

endmodule
